// File: rtl/nrs_rd_arbiter.sv
// Arbitrates the shared NRS register read port between the mapper (fixed priority) and the estimator (starvation-bounded).
// Grants are combinational and read data is registered one cycle after grant; requesters hold req until granted, and nothing is granted until the sequence is valid.
module nrs_rd_arbiter #(
  parameter int WIDTH_REG  = 16,
  parameter int LINES      = $clog2(WIDTH_REG),
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_subframe,
  input  logic                 nrs_gen_done,
  input  logic                 map_req,
  input  logic [LINES-1:0]     map_addr,
  input  logic                 est_req,
  input  logic [LINES-1:0]     est_addr,
  output logic [LINES-1:0]     reg_rd_addr,
  input  logic [WIDTH_REG-1:0] reg_rd_data,
  output logic                 map_gnt,
  output logic                 est_gnt,
  output logic [WIDTH_REG-1:0] map_rdata,
  output logic                 map_valid,
  output logic [WIDTH_REG-1:0] est_rdata,
  output logic                 est_valid,
  output logic                 seq_ready,
  output logic [4:0]           est_rd_cnt
);

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t           state;
  logic [3:0]       starve_cnt;
  logic [LINES-1:0] addr_q;
  logic             arb_en;
  logic             est_force;

  // A new_subframe cycle is already treated as invalid sequence, so it blocks grants.
  assign arb_en    = (state == ST_READY) && !new_subframe;
  assign est_force = est_req && (starve_cnt == STARVE_LIM);

  always_comb begin
    map_gnt = 1'b0;
    est_gnt = 1'b0;
    if (arb_en) begin
      if (est_force)    est_gnt = 1'b1;
      else if (map_req) map_gnt = 1'b1;
      else if (est_req) est_gnt = 1'b1;
    end
  end

  always_comb begin
    reg_rd_addr = addr_q;
    if (map_gnt)      reg_rd_addr = map_addr;
    else if (est_gnt) reg_rd_addr = est_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_WAIT;
      seq_ready  <= 1'b0;
      starve_cnt <= '0;
      addr_q     <= '0;
      map_rdata  <= '0;
      map_valid  <= 1'b0;
      est_rdata  <= '0;
      est_valid  <= 1'b0;
      est_rd_cnt <= '0;
    end else begin
      if (new_subframe) begin
        state     <= ST_WAIT;
        seq_ready <= 1'b0;
      end else if (nrs_gen_done) begin
        state     <= ST_READY;
        seq_ready <= 1'b1;
      end

      // Counts consecutive denials only; any break in the waiting streak restarts it.
      if ((state != ST_READY) || new_subframe || !est_req || est_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;

      if (map_gnt || est_gnt)
        addr_q <= reg_rd_addr;

      map_valid <= map_gnt;
      if (map_gnt)
        map_rdata <= reg_rd_data;

      est_valid <= est_gnt;
      if (est_gnt)
        est_rdata <= reg_rd_data;

      if (new_subframe)
        est_rd_cnt <= '0;
      else if (est_gnt && (est_rd_cnt != 5'd31))
        est_rd_cnt <= est_rd_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_nrs_rd_arbiter.sv
// Directed bench for nrs_rd_arbiter with a small behavioural NRS register array.
module tb_nrs_rd_arbiter;

  logic        clk;
  logic        rst;
  logic        new_subframe;
  logic        nrs_gen_done;
  logic        map_req;
  logic [3:0]  map_addr;
  logic        est_req;
  logic [3:0]  est_addr;
  logic [3:0]  reg_rd_addr;
  logic [15:0] reg_rd_data;
  logic        map_gnt;
  logic        est_gnt;
  logic [15:0] map_rdata;
  logic        map_valid;
  logic [15:0] est_rdata;
  logic        est_valid;
  logic        seq_ready;
  logic [4:0]  est_rd_cnt;

  logic [15:0] mem [16];
  int n_tests = 0;
  int n_fail  = 0;

  assign reg_rd_data = mem[reg_rd_addr];

  nrs_rd_arbiter #(.WIDTH_REG(16), .LINES(4), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .new_subframe(new_subframe), .nrs_gen_done(nrs_gen_done),
    .map_req(map_req), .map_addr(map_addr), .est_req(est_req), .est_addr(est_addr),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .map_gnt(map_gnt), .est_gnt(est_gnt), .map_rdata(map_rdata), .map_valid(map_valid),
    .est_rdata(est_rdata), .est_valid(est_valid), .seq_ready(seq_ready), .est_rd_cnt(est_rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_e;
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
    mem[3] = 16'h3C3C;
    mem[5] = 16'hA5A5;
    mem[7] = 16'h7E57;

    rst = 1'b1; new_subframe = 1'b0; nrs_gen_done = 1'b0;
    map_req = 1'b0; map_addr = '0; est_req = 1'b0; est_addr = '0;
    repeat (2) tick();
    check("rst_map_gnt",   32'(map_gnt),     32'd0);
    check("rst_est_gnt",   32'(est_gnt),     32'd0);
    check("rst_map_valid", 32'(map_valid),   32'd0);
    check("rst_est_valid", 32'(est_valid),   32'd0);
    check("rst_map_rdata", 32'(map_rdata),   32'd0);
    check("rst_est_rdata", 32'(est_rdata),   32'd0);
    check("rst_seq_ready", 32'(seq_ready),   32'd0);
    check("rst_est_cnt",   32'(est_rd_cnt),  32'd0);
    check("rst_rd_addr",   32'(reg_rd_addr), 32'd0);

    // Requests while the sequence is invalid are held off.
    rst = 1'b0; map_req = 1'b1; map_addr = 4'd3;
    for (int i = 0; i < 10; i++) begin
      #1 check("wait_map_gnt", 32'(map_gnt), 32'd0);
      tick();
    end
    check("wait_map_valid", 32'(map_valid), 32'd0);
    check("wait_seq_ready", 32'(seq_ready), 32'd0);

    // First grant the cycle after nrs_gen_done, data one cycle later.
    map_addr = 4'd5; nrs_gen_done = 1'b1;
    #1 check("done_cycle_gnt", 32'(map_gnt), 32'd0);
    tick();
    nrs_gen_done = 1'b0;
    #1 check("ready_seq_ready", 32'(seq_ready), 32'd1);
    check("first_map_gnt", 32'(map_gnt), 32'd1);
    check("first_rd_addr", 32'(reg_rd_addr), 32'd5);
    tick();
    map_req = 1'b0;
    #1 check("first_map_valid", 32'(map_valid), 32'd1);
    check("first_map_rdata", 32'(map_rdata), 32'hA5A5);
    check("idle_map_gnt", 32'(map_gnt), 32'd0);
    check("hold_rd_addr", 32'(reg_rd_addr), 32'd5);
    tick();
    check("idle_map_valid", 32'(map_valid), 32'd0);
    check("hold_map_rdata", 32'(map_rdata), 32'hA5A5);

    // Both contending: M,M,M,M,E repeating.
    map_req = 1'b1; est_req = 1'b1; map_addr = 4'd3; est_addr = 4'd7;
    for (int i = 0; i < 20; i++) begin
      exp_e = ((i % 5) == 4);
      #1 check("both_map_gnt", 32'(map_gnt), 32'(!exp_e));
      check("both_est_gnt", 32'(est_gnt), 32'(exp_e));
      check("both_rd_addr", 32'(reg_rd_addr), exp_e ? 32'd7 : 32'd3);
      tick();
      check("both_est_valid", 32'(est_valid), 32'(exp_e));
      check("both_map_valid", 32'(map_valid), 32'(!exp_e));
      if (exp_e) check("both_est_rdata", 32'(est_rdata), 32'h7E57);
      else       check("both_map_rdata", 32'(map_rdata), 32'h3C3C);
    end
    map_req = 1'b0; est_req = 1'b0;
    check("both_est_cnt", 32'(est_rd_cnt), 32'd4);

    // Estimator alone; count saturates at 31.
    new_subframe = 1'b1;
    tick();
    new_subframe = 1'b0;
    check("ns_cnt_clear", 32'(est_rd_cnt), 32'd0);
    check("ns_seq_ready", 32'(seq_ready), 32'd0);
    nrs_gen_done = 1'b1;
    tick();
    nrs_gen_done = 1'b0;
    check("est_seq_ready", 32'(seq_ready), 32'd1);
    est_req = 1'b1; est_addr = 4'd7;
    for (int k = 1; k <= 35; k++) begin
      #1 check("solo_est_gnt", 32'(est_gnt), 32'd1);
      tick();
      check("solo_est_valid", 32'(est_valid), 32'd1);
      check("solo_est_cnt", 32'(est_rd_cnt), (k > 31) ? 32'd31 : 32'(k));
    end
    new_subframe = 1'b1;
    #1 check("ns_est_gnt", 32'(est_gnt), 32'd0);
    check("ns_inflight_valid", 32'(est_valid), 32'd1);
    tick();
    new_subframe = 1'b0;
    check("ns_cnt_zero", 32'(est_rd_cnt), 32'd0);
    check("ns_seq_low", 32'(seq_ready), 32'd0);
    check("ns_valid_low", 32'(est_valid), 32'd0);
    #1 check("ns_wait_gnt", 32'(est_gnt), 32'd0);
    est_req = 1'b0;

    // Simultaneous new_subframe and nrs_gen_done: new_subframe wins.
    nrs_gen_done = 1'b1;
    tick();
    nrs_gen_done = 1'b0;
    check("sim_pre_ready", 32'(seq_ready), 32'd1);
    map_req = 1'b1; map_addr = 4'd3; new_subframe = 1'b1; nrs_gen_done = 1'b1;
    #1 check("sim_gnt", 32'(map_gnt), 32'd0);
    tick();
    new_subframe = 1'b0; nrs_gen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("sim_seq_ready", 32'(seq_ready), 32'd0);
      check("sim_wait_gnt", 32'(map_gnt), 32'd0);
      tick();
    end
    nrs_gen_done = 1'b1;
    tick();
    nrs_gen_done = 1'b0;
    #1 check("sim_regrant", 32'(map_gnt), 32'd1);
    tick();
    map_req = 1'b0;
    check("sim_map_valid", 32'(map_valid), 32'd1);
    check("sim_map_rdata", 32'(map_rdata), 32'h3C3C);

    // Reset mid-operation drops the in-flight valid and the count.
    est_req = 1'b1; est_addr = 4'd7;
    repeat (9) tick();
    est_req = 1'b0; map_req = 1'b1; map_addr = 4'd5;
    #1 check("pre_rst_gnt", 32'(map_gnt), 32'd1);
    tick();
    map_req = 1'b0;
    check("pre_rst_valid", 32'(map_valid), 32'd1);
    check("pre_rst_cnt", 32'(est_rd_cnt), 32'd9);
    rst = 1'b1;
    tick();
    check("mid_rst_map_valid", 32'(map_valid),   32'd0);
    check("mid_rst_est_valid", 32'(est_valid),   32'd0);
    check("mid_rst_map_rdata", 32'(map_rdata),   32'd0);
    check("mid_rst_est_rdata", 32'(est_rdata),   32'd0);
    check("mid_rst_seq_ready", 32'(seq_ready),   32'd0);
    check("mid_rst_cnt",       32'(est_rd_cnt),  32'd0);
    check("mid_rst_rd_addr",   32'(reg_rd_addr), 32'd0);
    rst = 1'b0; map_req = 1'b1;
    #1 check("post_rst_gnt", 32'(map_gnt), 32'd0);
    tick();
    check("post_rst_seq", 32'(seq_ready), 32'd0);
    map_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nrs_rd_arbiter.md
# nrs_rd_arbiter

Read-port arbiter for the NRS sequence register. The transmit mapper and the channel estimator both need NRS entries, but the register exposes one shared read address. This block sits between the register and the two requesters. It gates all reads until the control unit reports the current subframe's sequence as written, gives the mapper fixed priority, and guarantees the estimator a slot with a bounded starvation counter.

## Interface
Parameters:
- WIDTH_REG, 16, width of one NRS register entry / read data
- LINES, $clog2(WIDTH_REG), read address width
- STARVE_MAX, 4, consecutive estimator denials tolerated before the estimator wins (range 1..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- new_subframe  in  1  pulse; invalidates the current sequence
- nrs_gen_done  in  1  pulse from control unit; register now holds the valid sequence
- map_req  in  1  mapper read request, level, held until granted
- map_addr  in  LINES  mapper read address
- est_req  in  1  estimator read request, level, held until granted
- est_addr  in  LINES  estimator read address
- reg_rd_addr  out  LINES  shared read address to NRS register
- reg_rd_data  in  WIDTH_REG  register read data, combinational from reg_rd_addr
- map_gnt  out  1  combinational; mapper request accepted this cycle
- est_gnt  out  1  combinational; estimator request accepted this cycle
- map_rdata  out  WIDTH_REG  registered mapper read data
- map_valid  out  1  registered; map_rdata valid
- est_rdata  out  WIDTH_REG  registered estimator read data
- est_valid  out  1  registered; est_rdata valid
- seq_ready  out  1  registered; state is READY
- est_rd_cnt  out  5  estimator reads granted this subframe, saturating at 31

## Operation
- Two states:
  - WAIT: sequence invalid; no grants.
  - READY: arbitration active.
- Reset state is WAIT.
- WAIT -> READY on nrs_gen_done.
- READY -> WAIT on new_subframe.
- If new_subframe and nrs_gen_done arrive in the same cycle, new_subframe wins: the next state is WAIT from either state.
- In READY, arbitration per cycle:
  - starve_cnt == STARVE_MAX and est_req: estimator granted.
  - else map_req: mapper granted.
  - else est_req: estimator granted.
  - at most one grant per cycle.
- Grants are suppressed in any cycle where new_subframe is high.
- reg_rd_addr = granted requester's address. With no grant it holds the last driven value; reset value is 0.
- starve_cnt (4-bit, internal):
  - +1 in a READY cycle with est_req high and est_gnt low, saturating at STARVE_MAX.
  - cleared when est_gnt is high, when est_req is low, or on leaving READY.
  - reset value 0.
- Data capture:
  - on map_gnt, map_rdata <= reg_rd_data and map_valid <= 1 next cycle; otherwise map_valid <= 0 and map_rdata holds.
  - estimator side is identical with est_gnt, est_rdata and est_valid.
- est_rd_cnt increments on est_gnt, saturates at 31, and clears on new_subframe (clear wins over increment).
- Requests in WAIT are not an error. Requesters hold req and are served after READY is entered.

## Timing
- Reset values: map_gnt=0, est_gnt=0, map_valid=0, est_valid=0, map_rdata=0, est_rdata=0, seq_ready=0, est_rd_cnt=0, reg_rd_addr=0.
- Grant to valid latency: exactly 1 cycle. Back-to-back grants give one valid per cycle.
- nrs_gen_done in cycle t: seq_ready=1 and first grant possible in cycle t+1.
- new_subframe in cycle t: no grant in t, and seq_ready=0 from t+1. A read granted in t-1 still yields valid in t.
- Both requesting continuously in READY with STARVE_MAX=4: grant pattern M,M,M,M,E repeating.
- Reset asserted mid-operation: all outputs go to reset values on the next edge, and any in-flight valid is dropped.

## Test plan
- Reset then map_req=1, map_addr=3 with no nrs_gen_done for 10 cycles -> map_gnt=0 throughout, map_valid=0, seq_ready=0.
- Pulse nrs_gen_done, map_req=1, addr=5, reg_rd_data=16'hA5A5 -> map_gnt in the following cycle, then map_valid=1 with map_rdata=16'hA5A5 one cycle later.
- Both requests held 20 cycles in READY, STARVE_MAX=4 -> grants M,M,M,M,E repeated exactly 4 times; est_rd_cnt=4.
- Only est_req held, addr=7 -> est_gnt every cycle, est_valid continuous; est_rd_cnt saturates at 31 after 31 grants, then clears to 0 on new_subframe.
- new_subframe and nrs_gen_done in the same cycle while in READY -> state WAIT next cycle, seq_ready=0, no grants until a later nrs_gen_done.
- rst asserted while map_valid=1 and est_rd_cnt=9 -> next cycle all outputs are 0 and state is WAIT.
